// File: rtl/keychain_arith_pkg.sv
// Shared arithmetic definitions: divider FSM states and iteration-count helper.
package keychain_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Number of radix steps needed to retire every dividend bit.
    function automatic int div_iter_count(input int dividend_w, input int radix_bits);
        return (dividend_w + radix_bits - 1) / radix_bits;
    endfunction

endpackage

// File: rtl/mod_divider_if.sv
// Request/result bundle of the iterative modulus divider.
interface mod_divider_if #(
    parameter int WIDTH          = 16,
    parameter int DIVIDEND_WIDTH = 2 * WIDTH
);
    logic                      ready_in;
    logic [DIVIDEND_WIDTH-1:0] value_in;
    logic [WIDTH-1:0]          modulus_in;
    logic [WIDTH-1:0]          value_out;
    logic [DIVIDEND_WIDTH-1:0] quotient_out;
    logic                      busy_out;
    logic                      valid_out;
    logic                      error_out;

    modport master (
        output ready_in, value_in, modulus_in,
        input  value_out, quotient_out, busy_out, valid_out, error_out
    );

    modport slave (
        input  ready_in, value_in, modulus_in,
        output value_out, quotient_out, busy_out, valid_out, error_out
    );
endinterface

// File: rtl/mod_div_stage.sv
// One radix step of restoring division: shift in dividend bits, subtract the
// largest multiple of the modulus that fits, and emit that multiple as a digit.
module mod_div_stage #(
    parameter int WIDTH      = 16,
    parameter int RADIX_BITS = 2
) (
    input  logic [WIDTH-1:0]                          rem_in,
    input  logic [RADIX_BITS-1:0]                     bits_in,
    input  logic [(1<<RADIX_BITS)-1:1][WIDTH+1:0]     mult_in,
    output logic [WIDTH-1:0]                          rem_out,
    output logic [RADIX_BITS-1:0]                     digit_out
);
    localparam int PW = WIDTH + 2;
    localparam int NK = (1 << RADIX_BITS) - 1;

    logic [PW-1:0] part;

    assign part = PW'({rem_in, bits_in});

    // Multiples ascend, so the last one that fits is the largest; the result
    // therefore always stays below the modulus.
    always_comb begin
        digit_out = '0;
        rem_out   = WIDTH'(part);
        for (int k = 1; k <= NK; k++) begin
            if (part >= mult_in[k]) begin
                digit_out = RADIX_BITS'(k);
                rem_out   = WIDTH'(part - mult_in[k]);
            end
        end
    end

endmodule

// File: rtl/mod_divider.sv
// Iterative radix-2/4 divider producing quotient and remainder; a zero modulus
// short-circuits to an error result one cycle after accept.
module mod_divider
    import keychain_arith_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int DIVIDEND_WIDTH = 2 * WIDTH,
    parameter int RADIX_BITS     = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    mod_divider_if.slave  bus
);
    localparam int ITER  = div_iter_count(DIVIDEND_WIDTH, RADIX_BITS);
    localparam int EXT_W = ITER * RADIX_BITS;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam int NK    = (1 << RADIX_BITS) - 1;

    if (!(RADIX_BITS == 1 || RADIX_BITS == 2)) begin : g_bad_radix
        $error("mod_divider: RADIX_BITS must be 1 or 2");
    end

    div_state_e                       state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q;
    logic [EXT_W-1:0]                 div_q;
    logic [EXT_W-1:0]                 quo_q;
    logic [EXT_W-1:0]                 quo_next;
    logic [WIDTH-1:0]                 rem_q;
    logic [WIDTH-1:0]                 stage_rem;
    logic [RADIX_BITS-1:0]            stage_digit;
    logic [NK:1][WIDTH+1:0]           mult_q;
    logic                             accept;
    logic                             last_step;
    logic                             zero_mod;

    assign zero_mod      = (bus.modulus_in == '0);
    assign bus.busy_out  = (state_q == RUN);
    assign bus.valid_out = (state_q == DONE);

    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ready_in) begin
                    accept  = 1'b1;
                    state_d = zero_mod ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    last_step = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: combinational radix step on the registered partial remainder.
    mod_div_stage #(
        .WIDTH      (WIDTH),
        .RADIX_BITS (RADIX_BITS)
    ) u_stage (
        .rem_in    (rem_q),
        .bits_in   (div_q[EXT_W-1 -: RADIX_BITS]),
        .mult_in   (mult_q),
        .rem_out   (stage_rem),
        .digit_out (stage_digit)
    );

    assign quo_next = {quo_q[EXT_W-RADIX_BITS-1:0], stage_digit};

    // Stage p1: operand capture and per-iteration datapath update.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            div_q <= EXT_W'(bus.value_in);
            rem_q <= '0;
            quo_q <= '0;
            for (int k = 1; k <= NK; k++) begin
                mult_q[k] <= (WIDTH + 2)'(bus.modulus_in) * (WIDTH + 2)'(k);
            end
        end else if (state_q == RUN) begin
            div_q <= div_q << RADIX_BITS;
            rem_q <= stage_rem;
            quo_q <= quo_next;
        end
    end

    // Stage p2: iteration count and result registers, held until the next DONE.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q            <= '0;
            bus.value_out    <= '0;
            bus.quotient_out <= '0;
            bus.error_out    <= 1'b0;
        end else begin
            if (accept)              cnt_q <= '0;
            else if (state_q == RUN) cnt_q <= cnt_q + CNT_W'(1);

            if (accept && zero_mod) begin
                bus.error_out    <= 1'b1;
                bus.quotient_out <= '1;
                bus.value_out    <= '0;
            end else if (last_step) begin
                bus.error_out    <= 1'b0;
                bus.quotient_out <= DIVIDEND_WIDTH'(quo_next);
                bus.value_out    <= stage_rem;
            end
        end
    end

endmodule
